sfp_rx_channel_deframer: RTL

- Receive-side counterpart of the SFP TX path.
- Accepts 64-bit frames from the 10G Ethernet MAC RX AXI-Stream, validates the channel-frame header, length and MAC error flag, and buffers each frame store-and-forward in an internal FIFO.
- Forwards only complete, good frames to a downstream AXI-Stream consumer with backpressure.
- Bad frames are rolled back and counted.

---
 rtl/sfp_rx_channel_deframer_if.sv | 28 ++
 rtl/sfp_rx_channel_deframer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sfp_rx_channel_deframer_if.sv
// Stream bundle between the MAC RX path, the deframer and its downstream consumer.
// The MAC side has no TREADY: the deframer must take every valid beat.
interface sfp_rx_channel_deframer_if;
   logic [63:0] RX_S_AXIS_TDATA;
   logic [7:0]  RX_S_AXIS_TKEEP;
   logic        RX_S_AXIS_TVALID;
   logic        RX_S_AXIS_TLAST;
   logic        RX_S_AXIS_TUSER;
   logic [63:0] M_AXIS_TDATA;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY;
   logic        M_AXIS_TUSER;
   logic        M_AXIS_TLAST;

   // Environment view: feeds MAC beats, consumes the forwarded stream.
   modport master (
      output RX_S_AXIS_TDATA, RX_S_AXIS_TKEEP, RX_S_AXIS_TVALID, RX_S_AXIS_TLAST, RX_S_AXIS_TUSER,
      output M_AXIS_TREADY,
      input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST
   );

   // Deframer view.
   modport slave (
      input  RX_S_AXIS_TDATA, RX_S_AXIS_TKEEP, RX_S_AXIS_TVALID, RX_S_AXIS_TLAST, RX_S_AXIS_TUSER,
      input  M_AXIS_TREADY,
      output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST
   );
endinterface

// File: rtl/sfp_rx_channel_deframer.sv
// Store-and-forward RX channel deframer: validates header/length/MAC flag, buffers frames,
// forwards only committed good frames. Optional sequence check under SFP_RX_SEQ_CHECK_EN.
module sfp_rx_channel_deframer #(
   parameter int TX_RX_S_AXIS_WIDTH = 64,
   parameter int FIFO_DEPTH_LOG2    = 9,
   parameter int MAX_PAYLOAD_WORDS  = 256
) (
   input  logic                          RX_ACLK,
   input  logic                          RX_ARESET,
   sfp_rx_channel_deframer_if.slave      bus,
   output logic [15:0]                   FRAME_CNT,
   output logic [15:0]                   DROP_CNT,
   output logic [15:0]                   SEQ_ERR_CNT
);
   localparam int DW    = TX_RX_S_AXIS_WIDTH;
   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] PTR_ONE = 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   commit_ptr_q, commit_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]   remaining_q, remaining_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   logic [DW+1:0] mem [DEPTH];
   logic [DW+1:0] ram_rd_q;
   logic          mem_we;
   logic [DW+1:0] mem_wdata;

   logic          ram_valid_q, ram_valid_d;
   logic          m_valid_q, m_valid_d;
   logic          m_user_q, m_user_d;
   logic          m_last_q, m_last_d;
   logic [DW-1:0] m_data_q, m_data_d;

   logic          hdr_accept, frame_commit, frame_drop;
   logic          out_load, rd_en;

   logic [7:0]    hdr_magic;
   logic [15:0]   hdr_len;
   logic          keep_ok, last_word, hdr_ok;
   logic [AW:0]   used_words;
   logic [31:0]   free_words;

   assign hdr_magic  = bus.RX_S_AXIS_TDATA[63:56];
   assign hdr_len    = bus.RX_S_AXIS_TDATA[47:32];
   assign keep_ok    = (bus.RX_S_AXIS_TKEEP == 8'hFF);
   assign last_word  = (remaining_q == 16'd1);
   // Space is judged against the pre-edge rd_ptr, so a same-cycle read never over-promises.
   assign used_words = wr_ptr_q - rd_ptr_q;
   assign free_words = 32'(DEPTH) - 32'(used_words);
   assign hdr_ok     = (hdr_magic == 8'hAA) && (hdr_len != 16'd0)
                       && (32'(hdr_len) <= 32'(MAX_PAYLOAD_WORDS))
                       && keep_ok && !bus.RX_S_AXIS_TLAST
                       && (32'(hdr_len) + 32'd1 <= free_words);

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      remaining_d  = remaining_q;
      mem_we       = 1'b0;
      mem_wdata    = {2'b00, bus.RX_S_AXIS_TDATA};
      hdr_accept   = 1'b0;
      frame_commit = 1'b0;
      frame_drop   = 1'b0;
      if (bus.RX_S_AXIS_TVALID) begin
         case (state_q)
            ST_IDLE: begin
               if (hdr_ok) begin
                  mem_we          = 1'b1;
                  mem_wdata[DW+1] = 1'b1;
                  wr_ptr_d        = wr_ptr_q + PTR_ONE;
                  remaining_d     = hdr_len;
                  hdr_accept      = 1'b1;
                  state_d         = ST_PAYLOAD;
               end else begin
                  frame_drop = 1'b1;
                  state_d    = bus.RX_S_AXIS_TLAST ? ST_IDLE : ST_DISCARD;
               end
            end
            ST_PAYLOAD: begin
               mem_we        = 1'b1;
               mem_wdata[DW] = last_word;
               wr_ptr_d      = wr_ptr_q + PTR_ONE;
               remaining_d   = remaining_q - 16'd1;
               if (bus.RX_S_AXIS_TLAST) begin
                  state_d = ST_IDLE;
                  if (last_word && !bus.RX_S_AXIS_TUSER && keep_ok) begin
                     commit_ptr_d = wr_ptr_q + PTR_ONE;
                     frame_commit = 1'b1;
                  end else begin
                     wr_ptr_d   = commit_ptr_q;
                     frame_drop = 1'b1;
                  end
               end else if (last_word) begin
                  // Frame runs past its declared length: roll back and swallow the tail.
                  wr_ptr_d   = commit_ptr_q;
                  frame_drop = 1'b1;
                  state_d    = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (bus.RX_S_AXIS_TLAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign frame_cnt_d = sat_inc(frame_cnt_q, frame_commit);
   assign drop_cnt_d  = sat_inc(drop_cnt_q, frame_drop);

   // Two-stage read pipe (RAM register, output register) keeps 1 word/cycle under TREADY=1.
   always_comb begin
      out_load    = ram_valid_q && (!m_valid_q || bus.M_AXIS_TREADY);
      rd_en       = (rd_ptr_q != commit_ptr_q) && (!ram_valid_q || out_load);
      rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      ram_valid_d = rd_en ? 1'b1 : (out_load ? 1'b0 : ram_valid_q);
      m_valid_d   = out_load ? 1'b1 : (bus.M_AXIS_TREADY ? 1'b0 : m_valid_q);
      m_data_d    = m_data_q;
      m_user_d    = m_user_q;
      m_last_d    = m_last_q;
      if (out_load) begin
         m_data_d = ram_rd_q[DW-1:0];
         m_user_d = ram_rd_q[DW+1];
         m_last_d = ram_rd_q[DW];
      end
   end

   always_ff @(posedge RX_ACLK) begin
      if (mem_we) mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
      if (rd_en)  ram_rd_q <= mem[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge RX_ACLK) begin
      if (RX_ARESET) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         remaining_q  <= '0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         ram_valid_q  <= 1'b0;
         m_valid_q    <= 1'b0;
         m_user_q     <= 1'b0;
         m_last_q     <= 1'b0;
         m_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         remaining_q  <= remaining_d;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         ram_valid_q  <= ram_valid_d;
         m_valid_q    <= m_valid_d;
         m_user_q     <= m_user_d;
         m_last_q     <= m_last_d;
         m_data_q     <= m_data_d;
      end
   end

`ifdef SFP_RX_SEQ_CHECK_EN
   logic [31:0] cur_seq_q, cur_seq_d;
   logic [31:0] last_seq_q, last_seq_d;
   logic        seq_seen_q, seq_seen_d;
   logic [15:0] seq_err_cnt_q, seq_err_cnt_d;

   always_comb begin
      cur_seq_d     = hdr_accept ? bus.RX_S_AXIS_TDATA[31:0] : cur_seq_q;
      last_seq_d    = frame_commit ? cur_seq_q : last_seq_q;
      seq_seen_d    = seq_seen_q | frame_commit;
      seq_err_cnt_d = sat_inc(seq_err_cnt_q,
                              frame_commit && seq_seen_q && (cur_seq_q != last_seq_q + 32'd1));
   end

   always_ff @(posedge RX_ACLK) begin
      if (RX_ARESET) begin
         cur_seq_q     <= '0;
         last_seq_q    <= '0;
         seq_seen_q    <= 1'b0;
         seq_err_cnt_q <= '0;
      end else begin
         cur_seq_q     <= cur_seq_d;
         last_seq_q    <= last_seq_d;
         seq_seen_q    <= seq_seen_d;
         seq_err_cnt_q <= seq_err_cnt_d;
      end
   end

   assign SEQ_ERR_CNT = seq_err_cnt_q;
`else
   assign SEQ_ERR_CNT = 16'd0;
`endif

   assign FRAME_CNT         = frame_cnt_q;
   assign DROP_CNT          = drop_cnt_q;
   assign bus.M_AXIS_TDATA  = m_data_q;
   assign bus.M_AXIS_TVALID = m_valid_q;
   assign bus.M_AXIS_TUSER  = m_user_q;
   assign bus.M_AXIS_TLAST  = m_last_q;
endmodule
